// File: rtl/cic3_row_param.sv
// Row of NUM_CHANNELS third-order CIC decimators fed by 1-bit modulator streams.
// One shared decimation counter (ratio 2^dec_log2) gates the comb stages of every lane.
module cic3_lane #(
    parameter int OUT_W = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x_i,
    input  logic             en_i,
    input  logic             tick_i,
    output logic [OUT_W-1:0] out_o
);
    logic [OUT_W-1:0] i1_q, i2_q, i3_q;
    logic [OUT_W-1:0] s_dly_q, c1_dly_q, c2_dly_q;
    logic [OUT_W-1:0] out_q;
    logic [OUT_W-1:0] c1_d, c2_d, c3_d;

    // Comb chain evaluated on the current i3; only committed on tick.
    always_comb begin
        c1_d = i3_q - s_dly_q;
        c2_d = c1_d - c1_dly_q;
        c3_d = c2_d - c2_dly_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i1_q     <= '0;
            i2_q     <= '0;
            i3_q     <= '0;
            s_dly_q  <= '0;
            c1_dly_q <= '0;
            c2_dly_q <= '0;
            out_q    <= '0;
        end else if (!en_i) begin
            // Disabled lane sits in the zero state so re-enable starts clean.
            i1_q     <= '0;
            i2_q     <= '0;
            i3_q     <= '0;
            s_dly_q  <= '0;
            c1_dly_q <= '0;
            c2_dly_q <= '0;
            if (tick_i) out_q <= '0;
        end else begin
            i1_q <= i1_q + {{(OUT_W-1){1'b0}}, x_i};
            i2_q <= i2_q + i1_q;
            i3_q <= i3_q + i2_q;
            if (tick_i) begin
                s_dly_q  <= i3_q;
                c1_dly_q <= c1_d;
                c2_dly_q <= c2_d;
                out_q    <= c3_d;
            end
        end
    end

    assign out_o = out_q;
endmodule

module cic3_row_param #(
    parameter int NUM_CHANNELS = 24,
    parameter int MAX_DEC_LOG2 = 8,
    parameter int DEC_W        = 4,
    parameter int OUT_W        = 3*MAX_DEC_LOG2+1,
    parameter int CNT_W        = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CHANNELS-1:0]       in,
    input  logic [NUM_CHANNELS-1:0]       ch_en,
    input  logic [DEC_W-1:0]              dec_log2,
    output logic [NUM_CHANNELS*OUT_W-1:0] out,
    output logic                          out_valid,
    output logic [CNT_W-1:0]              sample_cnt
);
    logic [DEC_W-1:0]        r_log2_q;
    logic [MAX_DEC_LOG2-1:0] dcnt_q, dcnt_d;
    logic [MAX_DEC_LOG2-1:0] dmask;
    logic                    out_valid_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    tick;

    function automatic logic [DEC_W-1:0] clamp_log2(input logic [DEC_W-1:0] v);
        if (v == '0) return DEC_W'(1);
        if (32'(v) > MAX_DEC_LOG2) return DEC_W'(MAX_DEC_LOG2);
        return v;
    endfunction

    // R-1 as a mask; r_log2 == MAX_DEC_LOG2 shifts every one out, giving all-ones.
    assign dmask  = ~({MAX_DEC_LOG2{1'b1}} << r_log2_q);
    assign tick   = (dcnt_q == dmask);
    assign dcnt_d = tick ? '0 : dcnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            dcnt_q      <= '0;
            r_log2_q    <= clamp_log2(dec_log2);
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            dcnt_q      <= dcnt_d;
            out_valid_q <= tick;
            // Ratio only changes at a frame boundary so frames are never cut short.
            if (tick) begin
                r_log2_q <= clamp_log2(dec_log2);
                cnt_q    <= cnt_q + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_lane
        cic3_lane #(.OUT_W(OUT_W)) u_lane (
            .clk   (clk),
            .reset (reset),
            .x_i   (in[k]),
            .en_i  (ch_en[k]),
            .tick_i(tick),
            .out_o (out[k*OUT_W +: OUT_W])
        );
    end

    assign out_valid  = out_valid_q;
    assign sample_cnt = cnt_q;
endmodule
